// File: rtl/pd_bmc_rx.sv
// USB-PD BMC receiver: synchronises the CC line, times edge-to-edge intervals,
// locks onto an alternating preamble and then streams decoded bits.
module pd_bmc_rx (
    input  logic clk,
    input  logic rst,
    input  logic phy_cc_signal,
    input  logic rx_en,
    output logic rx_bit_valid,
    output logic rx_bit,
    output logic rx_active,
    output logic rx_done,
    output logic rx_err
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_HUNT      = 2'd1,
        ST_DATA      = 2'd2,
        ST_WAIT_IDLE = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic       s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [4:0] cnt_q, cnt_d, pre_q, pre_d;
    logic       pend_q, pend_d, last_q, last_d;
    logic       valid_q, valid_d, bit_q, bit_d, active_q, active_d;
    logic       done_q, done_d, err_q, err_d;

    logic cc_edge, timeout, is_short, is_long;
    logic bit_done, bit_val, bad, pend_nxt, alt_ok;

    // Interval classification and half-bit pairing for the edge seen this cycle
    always_comb begin
        cc_edge  = s2_q ^ s3_q;
        timeout  = ~cc_edge & (cnt_q == 5'd24);
        is_short = (cnt_q >= 5'd3) && (cnt_q <= 5'd5);
        is_long  = (cnt_q >= 5'd6) && (cnt_q <= 5'd10);
        bit_done = 1'b0;
        bit_val  = 1'b0;
        bad      = 1'b0;
        pend_nxt = pend_q;
        if (is_short) begin
            bit_done = pend_q;
            bit_val  = pend_q;
            pend_nxt = ~pend_q;
        end else if (is_long) begin
            bit_done = ~pend_q;
            bad      = pend_q;
            pend_nxt = 1'b0;
        end else begin
            bad      = 1'b1;
            pend_nxt = 1'b0;
        end
        alt_ok = (pre_q == 5'd0) ? ~bit_val : (bit_val ^ last_q);
    end

    // Next-state and registered-output logic
    always_comb begin
        s1_d     = phy_cc_signal;
        s2_d     = s1_q;
        s3_d     = s2_q;
        state_d  = state_q;
        cnt_d    = cc_edge ? 5'd1 : ((cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1);
        pre_d    = pre_q;
        pend_d   = pend_q;
        last_d   = last_q;
        valid_d  = 1'b0;
        bit_d    = 1'b0;
        active_d = active_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        if (!rx_en) begin
            state_d  = ST_IDLE;
            cnt_d    = 5'd0;
            pre_d    = 5'd0;
            pend_d   = 1'b0;
            last_d   = 1'b0;
            active_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    active_d = 1'b0;
                    if (cc_edge) begin
                        state_d = ST_HUNT;
                        pre_d   = 5'd0;
                        pend_d  = 1'b0;
                        last_d  = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_HUNT: begin
                    if (cc_edge) begin
                        pend_d = pend_nxt;
                        if (bad || (bit_done && !alt_ok)) begin
                            pre_d = 5'd0;
                        end else if (bit_done) begin
                            pre_d  = pre_q + 5'd1;
                            last_d = bit_val;
                            if (pre_q == 5'd15) begin
                                state_d  = ST_DATA;
                                active_d = 1'b1;
                            end else begin
                                state_d = ST_HUNT;
                            end
                        end else begin
                            pre_d = pre_q;
                        end
                    end else if (timeout) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HUNT;
                    end
                end
                ST_DATA: begin
                    if (cc_edge) begin
                        if (bad) begin
                            err_d    = 1'b1;
                            active_d = 1'b0;
                            pend_d   = 1'b0;
                            state_d  = ST_WAIT_IDLE;
                        end else begin
                            valid_d = bit_done;
                            bit_d   = bit_done & bit_val;
                            pend_d  = pend_nxt;
                        end
                    end else if (timeout) begin
                        // A dangling half-bit is dropped without any error
                        done_d   = 1'b1;
                        active_d = 1'b0;
                        pend_d   = 1'b0;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (timeout) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_IDLE;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    active_d = 1'b0;
                end
            endcase
        end
    end

    // State, synchroniser and output registers; the line idles high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q     <= 1'b1;
            s2_q     <= 1'b1;
            s3_q     <= 1'b1;
            state_q  <= ST_IDLE;
            cnt_q    <= 5'd0;
            pre_q    <= 5'd0;
            pend_q   <= 1'b0;
            last_q   <= 1'b0;
            valid_q  <= 1'b0;
            bit_q    <= 1'b0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pre_q    <= pre_d;
            pend_q   <= pend_d;
            last_q   <= last_d;
            valid_q  <= valid_d;
            bit_q    <= bit_d;
            active_q <= active_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign rx_bit_valid = valid_q;
    assign rx_bit       = bit_q;
    assign rx_active    = active_q;
    assign rx_done      = done_q;
    assign rx_err       = err_q;

endmodule

// File: tb/tb_pd_bmc_rx.sv
// Self-checking bench for pd_bmc_rx: toggle-time stimulus scored against an
// interval-level reference model of the receiver rules.
module tb_pd_bmc_rx;

    typedef struct {
        int stamp;
        int code;   // 0/1 bit, 2 err, 3 done, 4 active fall, 5 active rise
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cc  = 1'b1;
    logic en  = 1'b1;
    logic rx_bit_valid, rx_bit, rx_active, rx_done, rx_err;

    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic act_prev = 1'b0;
    bit   jsel = 1'b0;
    ev_t  expq[$];
    ev_t  dutq[$];
    int   tq[$];
    int   iv[$];

    pd_bmc_rx dut (
        .clk          (clk),
        .rst          (rst),
        .phy_cc_signal(cc),
        .rx_en        (en),
        .rx_bit_valid (rx_bit_valid),
        .rx_bit       (rx_bit),
        .rx_active    (rx_active),
        .rx_done      (rx_done),
        .rx_err       (rx_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk(int s, int c);
        ev_t e;
        e.stamp = s;
        e.code  = c;
        return e;
    endfunction

    // Event recorder, sampled on the inactive edge
    always @(negedge clk) begin
        if (rx_bit_valid === 1'b1) dutq.push_back(mk(cyc, (rx_bit === 1'b1) ? 1 : 0));
        if (rx_err === 1'b1) dutq.push_back(mk(cyc, 2));
        if (rx_done === 1'b1) dutq.push_back(mk(cyc, 3));
        if (rx_active !== act_prev) dutq.push_back(mk(cyc, (rx_active === 1'b1) ? 5 : 4));
        act_prev <= rx_active;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // mode 0: nominal 8/4+4, mode 1: full 7/9 and half 3/5 alternating, mode 2: random
    task automatic add_bit(int b, int mode);
        int f, h1, h2;
        if (mode == 0) begin
            f = 8; h1 = 4; h2 = 4;
        end else if (mode == 1) begin
            f  = jsel ? 9 : 7;
            h1 = jsel ? 5 : 3;
            h2 = 8 - h1;
            jsel = ~jsel;
        end else begin
            f  = int'($urandom_range(10, 6));
            h1 = int'($urandom_range(5, 3));
            h2 = int'($urandom_range(5, 3));
        end
        if (b == 0) iv.push_back(f);
        else begin
            iv.push_back(h1);
            iv.push_back(h2);
        end
    endtask

    task automatic play(int tail);
        foreach (iv[k]) begin
            repeat (iv[k]) @(negedge clk);
            cc = ~cc;
            tq.push_back(cyc);
        end
        repeat (tail) @(negedge clk);
        iv.delete();
    endtask

    task automatic clear_all();
        expq.delete();
        dutq.delete();
        tq.delete();
        iv.delete();
    endtask

    // Reference: walk toggle times, classify gaps and apply the receiver rules.
    // A toggle at stamp t shows its effect at t+3; idle timeout shows at t+27.
    task automatic run_model();
        int mode, pre, half, prev, gap, b;
        bit got, bad;
        mode = 0; pre = 0; half = 0; prev = 0; b = 0;
        expq.delete();
        for (int i = 0; i < tq.size(); i++) begin
            gap = (i > 0) ? tq[i] - tq[i-1] : 99;
            if (mode != 0 && gap >= 25) begin
                if (mode == 2) begin
                    expq.push_back(mk(tq[i-1] + 27, 3));
                    expq.push_back(mk(tq[i-1] + 27, 4));
                end
                mode = 0;
            end
            if (mode == 0) begin
                mode = 1; pre = 0; half = 0;
                continue;
            end
            if (mode == 3) continue;
            got = 0; bad = 0;
            if (gap >= 3 && gap <= 5) begin
                if (half != 0) begin got = 1; b = 1; half = 0; end
                else half = 1;
            end else if (gap >= 6 && gap <= 10 && half == 0) begin
                got = 1; b = 0;
            end else begin
                bad = 1; half = 0;
            end
            if (mode == 1) begin
                if (bad) pre = 0;
                else if (got) begin
                    if ((pre == 0 && b == 0) || (pre > 0 && b != prev)) begin
                        pre++;
                        prev = b;
                        if (pre == 16) begin
                            mode = 2;
                            expq.push_back(mk(tq[i] + 3, 5));
                        end
                    end else pre = 0;
                end
            end else begin
                if (bad) begin
                    expq.push_back(mk(tq[i] + 3, 2));
                    expq.push_back(mk(tq[i] + 3, 4));
                    mode = 3;
                end else if (got) expq.push_back(mk(tq[i] + 3, b));
            end
        end
        if (mode == 2 && tq.size() > 0) begin
            expq.push_back(mk(tq[tq.size()-1] + 27, 3));
            expq.push_back(mk(tq[tq.size()-1] + 27, 4));
        end
    endtask

    function automatic int count_code(int c);
        int n = 0;
        foreach (dutq[k]) if ((c < 0 && dutq[k].code < 2) || dutq[k].code == c) n++;
        return n;
    endfunction

    function automatic int frame_bit(int n);
        int tailb[4] = '{1, 1, 0, 0};
        return (n < 48) ? (n % 2) : tailb[n - 48];
    endfunction

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        n_vec++;
        if ({rx_bit_valid, rx_bit, rx_active, rx_done, rx_err} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b, expected 00000", {rx_bit_valid, rx_bit, rx_active, rx_done, rx_err});
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_vec++;
            if ({rx_bit_valid, rx_bit, rx_active, rx_done, rx_err} !== 5'b0) begin
                n_err++;
                $display("FAIL post_reset_%0d: got %b, expected 00000", k, {rx_bit_valid, rx_bit, rx_active, rx_done, rx_err});
            end
        end
    endtask

    task automatic test_frame(int mode, string name);
        int nb;
        clear_all();
        iv.push_back(3);
        for (int k = 0; k < 64; k++) add_bit(k % 2, mode);
        add_bit(1, mode); add_bit(1, mode); add_bit(0, mode); add_bit(0, mode);
        play(40);
        run_model();
        n_vec++;
        if (dutq.size() !== expq.size()) begin
            n_err++;
            $display("FAIL %s_events: got %0d events, expected %0d", name, dutq.size(), expq.size());
        end
        foreach (expq[k]) begin
            n_vec++;
            if (k >= dutq.size() || dutq[k].stamp !== expq[k].stamp || dutq[k].code !== expq[k].code) begin
                n_err++;
                $display("FAIL %s_ev%0d: got code %0d at %0d, expected code %0d at %0d", name, k,
                         (k < dutq.size()) ? dutq[k].code : -1, (k < dutq.size()) ? dutq[k].stamp : -1,
                         expq[k].code, expq[k].stamp);
            end
        end
        n_vec++;
        if (count_code(-1) !== 52 || count_code(3) !== 1 || count_code(2) !== 0) begin
            n_err++;
            $display("FAIL %s_counts: got %0d bits %0d done %0d err, expected 52 1 0", name,
                     count_code(-1), count_code(3), count_code(2));
        end
        nb = 0;
        foreach (dutq[k]) begin
            if (dutq[k].code < 2) begin
                n_vec++;
                if (dutq[k].code !== frame_bit(nb)) begin
                    n_err++;
                    $display("FAIL %s_bit%0d: got %0d, expected %0d", name, nb, dutq[k].code, frame_bit(nb));
                end
                nb++;
            end
        end
    endtask

    task automatic test_error();
        clear_all();
        iv.push_back(3);
        for (int k = 0; k < 16; k++) add_bit(k % 2, 0);
        for (int k = 0; k < 10; k++) add_bit(int'($urandom_range(1, 0)), 0);
        iv.push_back(13);
        for (int k = 0; k < 3; k++) iv.push_back(8);
        play(40);
        run_model();
        n_vec++;
        if (dutq.size() !== expq.size()) begin
            n_err++;
            $display("FAIL error_events: got %0d events, expected %0d", dutq.size(), expq.size());
        end
        foreach (expq[k]) begin
            n_vec++;
            if (k >= dutq.size() || dutq[k].stamp !== expq[k].stamp || dutq[k].code !== expq[k].code) begin
                n_err++;
                $display("FAIL error_ev%0d: got code %0d at %0d, expected code %0d at %0d", k,
                         (k < dutq.size()) ? dutq[k].code : -1, (k < dutq.size()) ? dutq[k].stamp : -1,
                         expq[k].code, expq[k].stamp);
            end
        end
        n_vec++;
        if (count_code(-1) !== 10 || count_code(2) !== 1 || count_code(3) !== 0) begin
            n_err++;
            $display("FAIL error_counts: got %0d bits %0d err %0d done, expected 10 1 0",
                     count_code(-1), count_code(2), count_code(3));
        end
    endtask

    task automatic test_hunt_restart();
        int lk, rise;
        clear_all();
        iv.push_back(3);
        for (int k = 0; k < 12; k++) add_bit(k % 2, 0);
        iv.push_back(4);
        iv.push_back(8);
        for (int k = 0; k < 16; k++) add_bit(k % 2, 0);
        lk = iv.size() - 1;
        for (int k = 0; k < 4; k++) add_bit(k % 2, 0);
        play(40);
        run_model();
        foreach (expq[k]) begin
            n_vec++;
            if (k >= dutq.size() || dutq[k].stamp !== expq[k].stamp || dutq[k].code !== expq[k].code) begin
                n_err++;
                $display("FAIL hunt_ev%0d: got code %0d at %0d, expected code %0d at %0d", k,
                         (k < dutq.size()) ? dutq[k].code : -1, (k < dutq.size()) ? dutq[k].stamp : -1,
                         expq[k].code, expq[k].stamp);
            end
        end
        rise = -1;
        foreach (dutq[k]) if (dutq[k].code == 5 && rise < 0) rise = dutq[k].stamp;
        n_vec++;
        if (rise !== tq[lk] + 3 || count_code(-1) !== 4) begin
            n_err++;
            $display("FAIL hunt_lock: got rise %0d bits %0d, expected rise %0d bits 4", rise, count_code(-1), tq[lk] + 3);
        end
    endtask

    task automatic test_random();
        int nj, np, nd, inj, v;
        for (int f = 0; f < 6; f++) begin
            clear_all();
            iv.push_back(3);
            nj = int'($urandom_range(5, 0));
            for (int k = 0; k < nj; k++) add_bit(int'($urandom_range(1, 0)), 2);
            np = int'($urandom_range(30, 16));
            for (int k = 0; k < np; k++) add_bit(k % 2, 2);
            nd  = int'($urandom_range(20, 4));
            inj = int'($urandom_range(2, 0));
            for (int k = 0; k < nd; k++) begin
                add_bit(int'($urandom_range(1, 0)), 2);
                if (inj == 0 && k == nd / 2) begin
                    v = int'($urandom_range(9, 0));
                    iv.push_back((v < 2) ? v + 1 : v + 9);
                end
            end
            if ($urandom_range(3, 0) == 0) iv.push_back(int'($urandom_range(5, 3)));
            play(40);
            run_model();
            n_vec++;
            if (dutq.size() !== expq.size()) begin
                n_err++;
                $display("FAIL random%0d_events: got %0d events, expected %0d", f, dutq.size(), expq.size());
            end
            foreach (expq[k]) begin
                n_vec++;
                if (k >= dutq.size() || dutq[k].stamp !== expq[k].stamp || dutq[k].code !== expq[k].code) begin
                    n_err++;
                    $display("FAIL random%0d_ev%0d: got code %0d at %0d, expected code %0d at %0d", f, k,
                             (k < dutq.size()) ? dutq[k].code : -1, (k < dutq.size()) ? dutq[k].stamp : -1,
                             expq[k].code, expq[k].stamp);
                end
            end
        end
    endtask

    task automatic test_disable();
        clear_all();
        iv.push_back(3);
        for (int k = 0; k < 20; k++) add_bit(k % 2, 0);
        add_bit(1, 0);
        add_bit(0, 0);
        play(5);
        n_vec++;
        if (rx_active !== 1'b1) begin
            n_err++;
            $display("FAIL disable_pre_active: got %b, expected 1", rx_active);
        end
        en = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({rx_bit_valid, rx_bit, rx_active, rx_done, rx_err} !== 5'b0) begin
            n_err++;
            $display("FAIL disable_outputs: got %b, expected 00000", {rx_bit_valid, rx_bit, rx_active, rx_done, rx_err});
        end
        dutq.delete();
        repeat (40) @(negedge clk);
        n_vec++;
        if (count_code(3) !== 0 || count_code(2) !== 0) begin
            n_err++;
            $display("FAIL disable_no_done: got %0d done %0d err, expected 0 0", count_code(3), count_code(2));
        end
        en = 1'b1;
        repeat (5) @(negedge clk);
        clear_all();
        iv.push_back(3);
        for (int k = 0; k < 20; k++) add_bit(k % 2, 2);
        for (int k = 0; k < 4; k++) add_bit(int'($urandom_range(1, 0)), 2);
        play(40);
        run_model();
        n_vec++;
        if (dutq.size() !== expq.size()) begin
            n_err++;
            $display("FAIL reenable_events: got %0d events, expected %0d", dutq.size(), expq.size());
        end
        foreach (expq[k]) begin
            n_vec++;
            if (k >= dutq.size() || dutq[k].stamp !== expq[k].stamp || dutq[k].code !== expq[k].code) begin
                n_err++;
                $display("FAIL reenable_ev%0d: got code %0d at %0d, expected code %0d at %0d", k,
                         (k < dutq.size()) ? dutq[k].code : -1, (k < dutq.size()) ? dutq[k].stamp : -1,
                         expq[k].code, expq[k].stamp);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int st2;
        clear_all();
        iv.push_back(3);
        for (int k = 0; k < 20; k++) add_bit(k % 2, 0);
        add_bit(1, 0);
        add_bit(0, 0);
        play(3);
        n_vec++;
        if (rx_active !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_pre_active: got %b, expected 1", rx_active);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (rx_active !== 1'b0 || rx_bit_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_async: got active %b valid %b, expected 0 0", rx_active, rx_bit_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        clear_all();
        iv.push_back(3);
        for (int k = 0; k < 10; k++) add_bit(k % 2, 0);
        st2 = iv.size();
        iv.push_back(30);
        for (int k = 0; k < 20; k++) add_bit(k % 2, 0);
        for (int k = 0; k < 3; k++) add_bit(int'($urandom_range(1, 0)), 0);
        play(40);
        run_model();
        n_vec++;
        if (dutq.size() == 0 || dutq[0].stamp <= tq[st2]) begin
            n_err++;
            $display("FAIL midrst_quiet: got first event at %0d, expected after %0d",
                     (dutq.size() > 0) ? dutq[0].stamp : -1, tq[st2]);
        end
        foreach (expq[k]) begin
            n_vec++;
            if (k >= dutq.size() || dutq[k].stamp !== expq[k].stamp || dutq[k].code !== expq[k].code) begin
                n_err++;
                $display("FAIL midrst_ev%0d: got code %0d at %0d, expected code %0d at %0d", k,
                         (k < dutq.size()) ? dutq[k].code : -1, (k < dutq.size()) ? dutq[k].stamp : -1,
                         expq[k].code, expq[k].stamp);
            end
        end
    endtask

    initial begin
        test_reset();
        repeat (5) @(negedge clk);
        test_frame(0, "nominal");
        test_frame(1, "jitter");
        test_error();
        test_hunt_restart();
        test_random();
        test_disable();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
